// File: rtl/codec_i2s_intf.sv
// I2S master for the stereo codec: derives MCLK/SCLK/LRCLK/RSTn from one frame
// counter, deserializes SDout and serializes the core's samples onto SDin.
// Optional digital loopback: define CODEC_LOOPBACK_EN to add the lpbk input.
module codec_i2s_intf #(
  parameter logic [9:0] CNT_RST = 10'h000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SDout,
`ifdef CODEC_LOOPBACK_EN
  input  logic        lpbk,
`endif
  input  logic [15:0] lft_out,
  input  logic [15:0] rht_out,
  output logic        MCLK,
  output logic        SCLK,
  output logic        LRCLK,
  output logic        RSTn,
  output logic        SDin,
  output logic [15:0] lft_in,
  output logic [15:0] rht_in,
  output logic        valid
);

  typedef enum logic {
    ST_CODEC_RST = 1'b0,
    ST_RUN       = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic        run;

  logic [9:0]  cnt_q, cnt_d;
  logic [15:0] rx_q, rx_d;
  logic [15:0] lft_in_q, lft_in_d;
  logic [15:0] rht_in_q, rht_in_d;
  logic        valid_q, valid_d;
  logic        left_ok_q, left_ok_d;
  logic [15:0] tx_lft_q, tx_lft_d;
  logic [15:0] tx_rht_q, tx_rht_d;
  logic [15:0] tx_q, tx_d;

  logic        sclk_rise, sclk_fall;
  logic        lft_cap, rht_cap;
  logic        ld_lft, ld_rht;
  logic [15:0] src_l, src_r;

  // Codec reset sequencer: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CODEC_RST;
    end else begin
      state_q <= state_d;
    end
  end

  // Codec reset sequencer: next state, leaves reset on the first counter wrap
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CODEC_RST: if (cnt_q == 10'h3FF) state_d = ST_RUN;
      ST_RUN:       state_d = ST_RUN;
      default:      state_d = ST_CODEC_RST;
    endcase
  end

  // Codec reset sequencer: outputs
  always_comb begin
    run = 1'b0;
    case (state_q)
      ST_RUN:  run = 1'b1;
      default: run = 1'b0;
    endcase
  end

  // Event decode is done on the next count so every action lands on the edge
  // where cnt becomes the named value.
  always_comb begin
    cnt_d     = cnt_q + 10'd1;
    sclk_rise = (cnt_d[4:0] == 5'b10000);
    sclk_fall = (cnt_d[4:0] == 5'b00000);
    lft_cap   = run && (cnt_d == 10'h211);
    rht_cap   = run && left_ok_q && (cnt_d == 10'h011);
    ld_lft    = (cnt_d == 10'h020);
    ld_rht    = (cnt_d == 10'h220);
  end

`ifdef CODEC_LOOPBACK_EN
  // rx_q holds the right word being captured on the same edge as rht_in
  always_comb begin
    src_l = lpbk ? lft_in_q : lft_out;
    src_r = lpbk ? rx_q     : rht_out;
  end
`else
  always_comb begin
    src_l = lft_out;
    src_r = rht_out;
  end
`endif

  always_comb begin
    rx_d      = rx_q;
    lft_in_d  = lft_in_q;
    rht_in_d  = rht_in_q;
    valid_d   = 1'b0;
    left_ok_d = left_ok_q;
    tx_lft_d  = tx_lft_q;
    tx_rht_d  = tx_rht_q;

    if (sclk_rise) rx_d = {rx_q[14:0], SDout};

    if (lft_cap) begin
      lft_in_d  = rx_q;
      left_ok_d = 1'b1;
    end else if (cnt_d == 10'h011) begin
      left_ok_d = 1'b0;
    end

    if (rht_cap) begin
      rht_in_d = rx_q;
      valid_d  = 1'b1;
      tx_lft_d = src_l;
      tx_rht_d = src_r;
    end
  end

  // Loads win over the coincident SCLK fall; zero fill pads past bit 0.
  always_comb begin
    tx_d = tx_q;
    if (!run) begin
      tx_d = '0;
    end else if (ld_lft) begin
      tx_d = tx_lft_q;
    end else if (ld_rht) begin
      tx_d = tx_rht_q;
    end else if (sclk_fall) begin
      tx_d = {tx_q[14:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= CNT_RST;
      rx_q      <= '0;
      lft_in_q  <= '0;
      rht_in_q  <= '0;
      valid_q   <= 1'b0;
      left_ok_q <= 1'b0;
      tx_lft_q  <= '0;
      tx_rht_q  <= '0;
      tx_q      <= '0;
    end else begin
      cnt_q     <= cnt_d;
      rx_q      <= rx_d;
      lft_in_q  <= lft_in_d;
      rht_in_q  <= rht_in_d;
      valid_q   <= valid_d;
      left_ok_q <= left_ok_d;
      tx_lft_q  <= tx_lft_d;
      tx_rht_q  <= tx_rht_d;
      tx_q      <= tx_d;
    end
  end

  assign MCLK   = cnt_q[1];
  assign SCLK   = cnt_q[4];
  assign LRCLK  = cnt_q[9];
  assign RSTn   = run;
  assign SDin   = tx_q[15];
  assign lft_in = lft_in_q;
  assign rht_in = rht_in_q;
  assign valid  = valid_q;

endmodule

// File: tb/tb_codec_i2s_intf.sv
// Self-checking bench for codec_i2s_intf: a frame-level codec model drives SDout
// and decodes SDin; expected values come from frame/slot arithmetic and queues.
module tb_codec_i2s_intf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        SDout;
  logic        lpbk_v;
  logic [15:0] lft_out, rht_out;
  logic        MCLK, SCLK, LRCLK, RSTn, SDin, valid;
  logic [15:0] lft_in, rht_in;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  int          n;
  int          ph;
  logic [15:0] lw [16];
  logic [15:0] rw [16];
  logic [15:0] exp_l, exp_r;
  logic [15:0] dec;
  logic [15:0] ql [$];
  logic [15:0] qr [$];

  always #10 clk = ~clk;

  codec_i2s_intf #(.CNT_RST(10'h000)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .SDout  (SDout),
`ifdef CODEC_LOOPBACK_EN
    .lpbk   (lpbk_v),
`endif
    .lft_out(lft_out),
    .rht_out(rht_out),
    .MCLK   (MCLK),
    .SCLK   (SCLK),
    .LRCLK  (LRCLK),
    .RSTn   (RSTn),
    .SDin   (SDin),
    .lft_in (lft_in),
    .rht_in (rht_in),
    .valid  (valid)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (n=%0d)", tag, got, exp, n);
    end
  endtask

  task automatic model_init();
    n = 0;
    for (int i = 0; i < 16; i++) begin
      lw[i] = 16'($urandom);
      rw[i] = 16'($urandom);
    end
    exp_l = '0;
    exp_r = '0;
    dec   = '0;
    ql.delete();
    qr.delete();
    SDout = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, 32'({MCLK, SCLK, LRCLK, RSTn, SDin, valid}), 32'd0);
    chk({tag, "_lft"}, 32'(lft_in), 32'd0);
    chk({tag, "_rht"}, 32'(rht_in), 32'd0);
  endtask

  // One clock: advance the frame model, compare, then drive the next inputs.
  task automatic step();
    int          c, f, s;
    logic        ev, bitv;
    logic        e_m, e_s, e_lr, e_rst;
    logic [15:0] w;
    @(posedge clk);
    n++;
    #1;
    c  = n % 1024;
    f  = n / 1024;
    ev = 1'b0;
    if (n >= 1024 && c == 'h211) exp_l = lw[f];
    if (n >= 1024 && c == 'h011 && f >= 2) begin
      ev    = 1'b1;
      exp_r = rw[f-1];
      ql.push_back(lpbk_v ? exp_l : lft_out);
      qr.push_back(lpbk_v ? exp_r : rht_out);
    end

    e_m   = ((n % 4) >= 2);
    e_s   = ((n % 32) >= 16);
    e_lr  = (c >= 512);
    e_rst = (n >= 1024);
    chk("ctl", 32'({MCLK, SCLK, LRCLK, RSTn, valid}), 32'({e_m, e_s, e_lr, e_rst, ev}));
    chk("lft_in", 32'(lft_in), 32'(exp_l));
    chk("rht_in", 32'(rht_in), 32'(exp_r));
    if (n < 1024) chk("sdin_rst", 32'(SDin), 32'd0);

    if (ph == 1 && n == 2065) begin
      chk("rx_a5c3", 32'(lft_in), 32'h0000A5C3);
      chk("rx_1234", 32'(rht_in), 32'h00001234);
    end

    // Codec side samples SDin on each SCLK rise
    if (c % 32 == 16) begin
      dec = {dec[14:0], SDin};
      if (c == 'h210) begin
        if (f >= 2) w = ql.pop_front();
        else        w = '0;
        chk("tx_lft", 32'(dec), 32'(w));
        if (ph == 1 && f == 2) chk("tx_8001", 32'(dec), 32'h00008001);
        if (ph == 1 && f == 3) chk("tx_0f0f", 32'(dec), 32'h00000F0F);
`ifdef CODEC_LOOPBACK_EN
        if (ph == 2 && f == 4) chk("lpbk_beef", 32'(dec), 32'h0000BEEF);
`endif
      end
      if (c == 'h010 && f >= 1) begin
        if (f >= 3) w = qr.pop_front();
        else        w = '0;
        chk("tx_rht", 32'(dec), 32'(w));
        if (ph == 1 && f == 3) chk("tx_7ffe", 32'(dec), 32'h00007FFE);
`ifdef CODEC_LOOPBACK_EN
        if (ph == 2 && f == 5) chk("lpbk_cafe", 32'(dec), 32'h0000CAFE);
`endif
      end
    end

    // I2S codec: slot s>=1 carries bit 16-s of this half's word, slot 0 the
    // LSB of the previous half's word.
    s = (c % 512) / 32;
    if (s == 0) begin
      if (c >= 512)   bitv = lw[f][0];
      else if (f > 0) bitv = rw[f-1][0];
      else            bitv = 1'b0;
    end else begin
      if (c >= 512) bitv = rw[f][16-s];
      else          bitv = lw[f][16-s];
    end
    SDout = bitv;

    if (ph == 1 && n == 2066) lft_out = 16'h0F0F;
`ifdef CODEC_LOOPBACK_EN
    if (ph == 2 && n == 3 * 1024) lpbk_v = 1'b1;
`endif
    if (ph == 2 || n > 4 * 1024) begin
      if ($urandom_range(0, 99) == 0) lft_out = 16'($urandom);
      if ($urandom_range(0, 99) == 0) rht_out = 16'($urandom);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    lpbk_v  = 1'b0;
    lft_out = 16'h8001;
    rht_out = 16'h7FFE;
    ph      = 1;
    model_init();
    lw[1] = 16'hA5C3;
    rw[1] = 16'h1234;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("rst_init");
    @(negedge clk);
    rst_n = 1'b1;

    while (!(n / 1024 == 4 && n % 1024 == 'h150)) step();

    // Reset in the middle of a left word
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    ph = 2;
    model_init();
    lw[3] = 16'hBEEF;
    rw[3] = 16'hCAFE;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    repeat (7 * 1024) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
